// File: rtl/iomem_initiator_if.sv
// Command/response stream and PicoSoC iomem bus signals of the iomem initiator.
// The master modport is the initiator's view; slave is the view of whatever drives it.
interface iomem_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        input  rsp_ready,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        output rsp_ready,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_initiator.sv
// Turns one command into one iomem bus transaction and returns read data or a
// timeout indication; a single transaction is outstanding at a time.
module iomem_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                resetn,
    iomem_initiator_if.master   bus,
    output logic                busy,
    output logic [7:0]          err_count
);

    localparam int TimerWidth = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t                  state_q;
    logic [TimerWidth-1:0]   timer_q;
    logic                    cmdReady_q;
    logic                    iomemValid_q;
    logic [3:0]              iomemWstrb_q;
    logic [31:0]             iomemAddr_q;
    logic [31:0]             iomemWdata_q;
    logic                    rspValid_q;
    logic [31:0]             rspRdata_q;
    logic                    rspTimeout_q;
    logic                    busy_q;
    logic [7:0]              errCount_q;
    logic                    timeoutHit;

    // A zero TIMEOUT_CYCLES leaves the request pending until the responder answers.
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (timer_q == TimerLast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cmdReady_q   <= 1'b1;
            iomemValid_q <= 1'b0;
            iomemWstrb_q <= 4'h0;
            iomemAddr_q  <= 32'h0;
            iomemWdata_q <= 32'h0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= 32'h0;
            rspTimeout_q <= 1'b0;
            busy_q       <= 1'b0;
            errCount_q   <= 8'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmdReady_q) begin
                        iomemAddr_q  <= bus.cmd_addr;
                        iomemWdata_q <= bus.cmd_wdata;
                        iomemWstrb_q <= bus.cmd_write ? bus.cmd_wstrb : 4'h0;
                        timer_q      <= '0;
                        iomemValid_q <= 1'b1;
                        cmdReady_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // Ready in the last counted cycle still completes successfully.
                    if (bus.iomem_ready) begin
                        rspRdata_q   <= bus.iomem_rdata;
                        rspTimeout_q <= 1'b0;
                        iomemValid_q <= 1'b0;
                        rspValid_q   <= 1'b1;
                        state_q      <= RESP;
                    end else if (timeoutHit) begin
                        rspRdata_q   <= 32'h0;
                        rspTimeout_q <= 1'b1;
                        iomemValid_q <= 1'b0;
                        rspValid_q   <= 1'b1;
                        if (errCount_q != 8'hFF) begin
                            errCount_q <= errCount_q + 8'd1;
                        end
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rspValid_q <= 1'b0;
                        cmdReady_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmdReady_q;
    assign bus.iomem_valid = iomemValid_q;
    assign bus.iomem_wstrb = iomemWstrb_q;
    assign bus.iomem_addr  = iomemAddr_q;
    assign bus.iomem_wdata = iomemWdata_q;
    assign bus.rsp_valid   = rspValid_q;
    assign bus.rsp_rdata   = rspRdata_q;
    assign bus.rsp_timeout = rspTimeout_q;
    assign busy            = busy_q;
    assign err_count       = errCount_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator with TIMEOUT_CYCLES = 16; inputs change and
// outputs are sampled on the falling clock edge.
module tb_iomem_initiator;

    logic       clk = 1'b0;
    logic       resetn;
    logic       busy;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    iomem_initiator_if bus ();

    iomem_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a command for one edge; returns at the falling edge of the first REQ cycle.
    task automatic issueCmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finishRsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = 32'h0;
        bus.cmd_wdata   = 32'h0;
        bus.cmd_wstrb   = 4'h0;
        bus.rsp_ready   = 1'b0;
        bus.iomem_ready = 1'b0;
        bus.iomem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout, busy} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 10000",
                     {bus.cmd_ready, bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout, busy});
        end
        checks++;
        if ({bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata, bus.rsp_rdata, err_count} !== 108'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 0",
                     {bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata, bus.rsp_rdata, err_count});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        issueCmd(1'b1, 32'h0300_0000, 32'h0000_00A5, 4'hF);
        checks++;
        if ({bus.iomem_valid, bus.cmd_ready, busy, bus.rsp_valid} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL wr_e1_flags got %b want 1010",
                     {bus.iomem_valid, bus.cmd_ready, busy, bus.rsp_valid});
        end
        checks++;
        if ({bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata} !== {4'hF, 32'h0300_0000, 32'h0000_00A5}) begin
            errors++;
            $display("[TB] FAIL wr_bus got %h want f03000000000000a5",
                     {bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata});
        end
        tick();
        checks++;
        if ({bus.iomem_valid, bus.rsp_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL wr_e2_flags got %b want 10", {bus.iomem_valid, bus.rsp_valid});
        end
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL wr_e3_flags got %b want 010",
                     {bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout});
        end
        checks++;
        if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL wr_rdata got %h want deadbeef", bus.rsp_rdata);
        end
        finishRsp();
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL wr_done got %b want 010", {bus.rsp_valid, bus.cmd_ready, busy});
        end
    endtask

    task automatic test_read();
        issueCmd(1'b0, 32'h0600_0000, 32'h1234_5678, 4'hF);
        checks++;
        if ({bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr} !== {1'b1, 4'h0, 32'h0600_0000}) begin
            errors++;
            $display("[TB] FAIL rd_bus got %h want 1006000000",
                     {bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr});
        end
        tick();
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'h0000_0003;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata} !== {2'b10, 32'h0000_0003}) begin
            errors++;
            $display("[TB] FAIL rd_rsp got %h want 200000003",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata});
        end
        finishRsp();
        // Zero strobes on a write becomes a read; ready in the first REQ cycle gives 2-cycle latency.
        issueCmd(1'b1, 32'h0600_0010, 32'hFFFF_FFFF, 4'h0);
        checks++;
        if (bus.iomem_wstrb !== 4'h0) begin
            errors++;
            $display("[TB] FAIL wstrb0_as_read got %h want 0", bus.iomem_wstrb);
        end
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'h0BAD_F00D;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.iomem_valid, bus.rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            errors++;
            $display("[TB] FAIL min_latency got %h want 20badf00d",
                     {bus.rsp_valid, bus.iomem_valid, bus.rsp_rdata});
        end
        finishRsp();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        issueCmd(1'b0, 32'h0700_0000, 32'h0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            if (!bus.iomem_valid) break;
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("[TB] FAIL to_valid_cycles got %0d want 16", cnt);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count} !== {2'b11, 32'h0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL to_rsp got %h want 30000000001",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count});
        end
        finishRsp();
    endtask

    task automatic test_late_ready();
        issueCmd(1'b0, 32'h0700_0000, 32'h0, 4'h0);
        repeat (15) tick();
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'hCAFE_F00D;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count} !== {2'b10, 32'hCAFE_F00D, 8'd1}) begin
            errors++;
            $display("[TB] FAIL ready_16th got %h want 2cafef00d01",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count});
        end
        finishRsp();
        issueCmd(1'b0, 32'h0700_0000, 32'h0, 4'h0);
        repeat (16) tick();
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'h1111_1111;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count} !== {2'b11, 32'h0, 8'd2}) begin
            errors++;
            $display("[TB] FAIL ready_17th got %h want 30000000002",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count});
        end
        finishRsp();
        bus.iomem_ready = 1'b1;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.cmd_ready, busy, bus.rsp_valid, bus.iomem_valid} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL idle_ready_ignored got %b want 1000",
                     {bus.cmd_ready, busy, bus.rsp_valid, bus.iomem_valid});
        end
    endtask

    task automatic test_back_to_back();
        int badCycles = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0300_0004;
        bus.cmd_wdata = 32'h0000_0011;
        bus.cmd_wstrb = 4'h1;
        tick();
        bus.cmd_addr  = 32'h0300_0008;
        bus.cmd_wdata = 32'h0000_0022;
        tick();
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'h0000_55AA;
        tick();
        bus.iomem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.cmd_ready, busy, bus.iomem_valid}
                    !== {2'b10, 32'h0000_55AA, 3'b010}) begin
                badCycles++;
            end
            if (i < 4) tick();
        end
        checks++;
        if (badCycles !== 0) begin
            errors++;
            $display("[TB] FAIL backpressure_hold got %0d bad cycles want 0", badCycles);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.iomem_valid, bus.iomem_addr} !== {3'b100, 32'h0300_0004}) begin
            errors++;
            $display("[TB] FAIL b2b_idle got %h want 403000004",
                     {bus.cmd_ready, bus.rsp_valid, bus.iomem_valid, bus.iomem_addr});
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.iomem_valid, bus.iomem_addr, bus.iomem_wdata} !== {1'b1, 32'h0300_0008, 32'h0000_0022}) begin
            errors++;
            $display("[TB] FAIL b2b_second got %h want 10300000800000022",
                     {bus.iomem_valid, bus.iomem_addr, bus.iomem_wdata});
        end
        bus.iomem_ready = 1'b1;
        tick();
        bus.iomem_ready = 1'b0;
        finishRsp();
    endtask

    task automatic test_saturation();
        int stuck = 0;
        for (int n = 0; n < 298; n++) begin
            issueCmd(1'b0, 32'h0700_0000, 32'h0, 4'h0);
            for (int i = 0; i < 40 && !bus.rsp_valid; i++) tick();
            if (!bus.rsp_valid) stuck++;
            finishRsp();
        end
        checks++;
        if (stuck !== 0) begin
            errors++;
            $display("[TB] FAIL sat_no_response got %0d want 0", stuck);
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL err_count_saturate got %0d want 255", err_count);
        end
    endtask

    task automatic test_reset_mid();
        issueCmd(1'b0, 32'h0600_0000, 32'h0, 4'h0);
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'hABCD_1234;
        tick();
        bus.iomem_ready = 1'b0;
        finishRsp();
        issueCmd(1'b1, 32'h0700_0004, 32'h0000_5A5A, 4'h3);
        tick();
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout, busy} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL midreset_flags got %b want 10000",
                     {bus.cmd_ready, bus.iomem_valid, bus.rsp_valid, bus.rsp_timeout, busy});
        end
        checks++;
        if ({bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata, bus.rsp_rdata, err_count} !== 108'h0) begin
            errors++;
            $display("[TB] FAIL midreset_data got %h want 0",
                     {bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata, bus.rsp_rdata, err_count});
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        issueCmd(1'b0, 32'h0600_0000, 32'h0, 4'h0);
        tick();
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'h0000_0077;
        tick();
        bus.iomem_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count} !== {2'b10, 32'h0000_0077, 8'd0}) begin
            errors++;
            $display("[TB] FAIL post_reset_read got %h want 20000007700",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, err_count});
        end
        finishRsp();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_late_ready();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
